// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//
// Receive-side buffer sitting between a UART receiver and its consumer.
// First-word-fall-through FIFO: the oldest stored word is always visible on
// rd_data, and rd_en pops it.
//
// Parameters
//   DATA_BITS  width of one received word (default 8)
//   ADDR_BITS  pointer width; depth is 2**ADDR_BITS words (default 16)
//
// Ports
//   clk_50MHz     system clock, rising-edge active
//   reset         asynchronous, active-high reset
//   wr_en         write strobe (receiver data_ready pulse)
//   wr_data       write word (receiver data_out)
//   rd_en         pop request from the consumer
//   rd_data       head word, valid while empty = 0
//   empty         no words stored
//   full          2**ADDR_BITS words stored
//   count         number of stored words (ADDR_BITS+1 bits)
//   overflow      sticky: a write was dropped because the FIFO was full
//   overflow_clr  synchronous clear of overflow (a same-cycle drop wins)
//   almost_full   count >= depth-2; present only when the macro
//                 UART_RX_FIFO_ALMOST_FULL_EN is defined
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 4
) (
    input  logic                 clk_50MHz,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 empty,
    output logic                 full,
    output logic [ADDR_BITS:0]   count,
    output logic                 overflow,
    input  logic                 overflow_clr
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    ,
    output logic                 almost_full
`endif
);

    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS:0]   DEPTH_C = (ADDR_BITS + 1)'(DEPTH);
    localparam logic [ADDR_BITS:0]   CNT_ONE = (ADDR_BITS + 1)'(1);
    localparam logic [ADDR_BITS-1:0] PTR_ONE = ADDR_BITS'(1);

    // Storage is deliberately not reset; only pointers and count are.
    logic [DATA_BITS-1:0] r_mem [DEPTH];

    logic [ADDR_BITS-1:0] r_wr_ptr;
    logic [ADDR_BITS-1:0] r_rd_ptr;
    logic [ADDR_BITS:0]   r_count;
    logic                 r_overflow;

    logic w_full;
    logic w_empty;
    logic w_wr_accept;
    logic w_rd_accept;
    logic w_drop;

    // Flags come from the registered count only, so there is no
    // combinational path from the strobes to empty/full.
    assign w_full  = (r_count == DEPTH_C);
    assign w_empty = (r_count == '0);

    // When full, a simultaneous pop frees the head slot in the same edge;
    // wr_ptr equals rd_ptr then, so the new word lands in the slot being
    // vacated and becomes the tail.
    assign w_wr_accept = wr_en && (!w_full || rd_en);
    assign w_rd_accept = rd_en && !w_empty;
    assign w_drop      = wr_en && w_full && !rd_en;

    always_ff @(posedge clk_50MHz) begin
        if (w_wr_accept) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at their ADDR_BITS width.
    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd_accept) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            case ({w_wr_accept, w_rd_accept})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (overflow_clr) begin
            r_overflow <= 1'b0;
        end
    end

    assign rd_data  = r_mem[r_rd_ptr];
    assign empty    = w_empty;
    assign full     = w_full;
    assign count    = r_count;
    assign overflow = r_overflow;

`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    localparam logic [ADDR_BITS:0] AF_LEVEL = DEPTH_C - (ADDR_BITS + 1)'(2);

    assign almost_full = (r_count >= AF_LEVEL);
`endif

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DATA_BITS, default 8, SHALL set the width of one received word.
REQ-002 Parameter ADDR_BITS, default 4, SHALL set the FIFO depth to 2**ADDR_BITS words (16 by default).
REQ-003 Port clk_50MHz, input, 1, SHALL be the system clock; all state changes occur on its rising edge.
REQ-004 Port reset, input, 1, SHALL be the reset, asynchronous, active-high.
REQ-005 Port wr_en, input, 1, SHALL be the write strobe, driven by the receiver's data_ready pulse.
REQ-006 Port wr_data, input, DATA_BITS, SHALL carry the write word, driven by the receiver's data_out.
REQ-007 Port rd_en, input, 1, SHALL be the consumer pop request.
REQ-008 Port rd_data, output, DATA_BITS, SHALL present the head word (first-word-fall-through).
REQ-009 Port empty, output, 1, SHALL be high when count == 0.
REQ-010 Port full, output, 1, SHALL be high when count == 2**ADDR_BITS.
REQ-011 Port count, output, ADDR_BITS+1, SHALL give the number of stored words.
REQ-012 Port overflow, output, 1, SHALL be a sticky flag set when a write is dropped.
REQ-013 Port overflow_clr, input, 1, SHALL clear overflow synchronously.
REQ-014 Port almost_full, output, 1, SHALL exist only when UART_RX_FIFO_ALMOST_FULL_EN is defined.

Function
REQ-015 Storage SHALL be a 2**ADDR_BITS x DATA_BITS register array with ADDR_BITS-wide write and read pointers that wrap from 2**ADDR_BITS-1 to 0.
REQ-016 A write SHALL be accepted when wr_en=1 and (full=0 or rd_en=1); the word is stored at wr_ptr and wr_ptr increments at that edge.
REQ-017 A pop SHALL be accepted when rd_en=1 and empty=0; rd_ptr increments at that edge.
REQ-018 rd_data SHALL be combinationally mem[rd_ptr]; a written word SHALL appear on rd_data, with empty=0, one cycle after the write edge.
REQ-019 rd_data SHALL be unspecified while empty=1; rd_en while empty SHALL be ignored, with no pointer or count change.
REQ-020 count SHALL increase by 1 on write only, decrease by 1 on pop only, and stay unchanged on simultaneous accepted write and pop.
REQ-021 When full and wr_en=1 and rd_en=1, both SHALL occur and full SHALL remain 1.
REQ-022 When empty and wr_en=1 and rd_en=1, only the write SHALL occur, giving count=1.
REQ-023 A write attempted while full without rd_en SHALL be dropped; memory, pointers and count SHALL be unchanged, and overflow SHALL be set at that edge.
REQ-024 overflow SHALL stay 1 until overflow_clr=1; if a drop and overflow_clr occur in the same cycle, set SHALL win.
REQ-025 empty, full and overflow SHALL be registered or derived from registered count, with no combinational path from wr_en or rd_en.

Reset
REQ-026 Reset assertion SHALL force wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0 and overflow=0 immediately, independent of the clock.
REQ-027 Memory contents SHALL NOT be reset.
REQ-028 Reset asserted mid-operation SHALL discard all stored words.
REQ-029 The first write SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-030 With UART_RX_FIFO_ALMOST_FULL_EN defined, almost_full SHALL be 1 when count >= 2**ADDR_BITS-2; it SHALL be 0 out of reset.
REQ-031 Without UART_RX_FIFO_ALMOST_FULL_EN, the almost_full port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 Write 0x41, 0x42, 0x43 on separate cycles, then pop three times -> rd_data 0x41, 0x42, 0x43 in order; empty=1 and count=0 at the end.
REQ-033 Write 16 words 0x00..0x0F, then write 0xAA -> full=1, count=16, overflow=1; pops return 0x00..0x0F and 0xAA is never returned.
REQ-034 While full, apply wr_en=1 with 0x55 and rd_en=1 -> head popped, count stays 16, 0x55 becomes the last word read, overflow unchanged.
REQ-035 While empty, apply wr_en=1 with 0x7E and rd_en=1 -> count=1 and rd_data=0x7E on the next cycle.
REQ-036 Perform 40 write/pop pairs covering pointer wrap, then assert reset mid-stream with count=5 -> count=0, empty=1 and overflow=0 immediately; then set overflow and pulse overflow_clr -> overflow=0 on the next edge.
REQ-037 With UART_RX_FIFO_ALMOST_FULL_EN defined, fill to 13 words then 14 -> almost_full 0 at 13 and 1 at 14; pop one -> almost_full=0.
